stp_buffer: RTL
===============

Name: stp_buffer

Overview:
Serial-to-parallel frame collector at the FFT input side, the counterpart of the PtS output wrapper. It accepts one DATA_W-bit sample per in_strobe and assembles NUM_SAMPLES samples into a frame. It presents the complete frame as a flattened parallel bus to the FFT core with a valid/ack handshake. A one-frame collect buffer lets reception of the next frame overlap with the consumer holding the current one.

Parameters:
DATA_W, 16, sample width in bits
NUM_SAMPLES, 32, samples per frame (power of 2, >= 2)

Ports:
clk  input  1  system clock, 400 MHz
n_rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous frame abort/restart
in_strobe  input  1  serial_in holds a valid sample this cycle
serial_in  input  DATA_W  serial sample
par_out  output  NUM_SAMPLES*DATA_W  parallel frame; sample k at bits [k*DATA_W +: DATA_W]
frame_valid  output  1  par_out holds a complete, unconsumed frame
frame_ack  input  1  consumer takes par_out; meaningful only while frame_valid=1
sample_count  output  $clog2(NUM_SAMPLES)  index of next sample slot in collect buffer
overflow  output  1  sticky: a sample was dropped

Behaviour:
- Reset (n_rst=0, async): par_out=0, frame_valid=0, sample_count=0, overflow=0, state=COLLECT, collect buffer=0.
- Ordering: first sample received after frame start goes to slot 0 (par_out LSB word), last goes to slot NUM_SAMPLES-1.
- "Holding free" this cycle = (frame_valid=0) or (frame_ack=1).
- State COLLECT:
  - in_strobe with sample_count<NUM_SAMPLES-1: buf[sample_count]<=serial_in; sample_count++.
  - in_strobe with sample_count=NUM_SAMPLES-1 and holding free: par_out<=buf with slot NUM_SAMPLES-1 = serial_in; frame_valid<=1; sample_count<=0; stay COLLECT. Zero-cycle latency: frame_valid is high in the cycle after the edge that captured the last sample.
  - in_strobe with sample_count=NUM_SAMPLES-1 and holding busy: buf[NUM_SAMPLES-1]<=serial_in; go PENDING; sample_count stays NUM_SAMPLES-1.
  - frame_ack with no frame completion this cycle: frame_valid<=0.
- State PENDING (collect buffer full, waiting for consumer):
  - frame_ack=1: par_out<=buf; frame_valid stays 1 (new frame); sample_count<=0; go COLLECT.
  - in_strobe in PENDING, including the ack cycle: sample dropped, overflow<=1. Buffer and par_out are not modified.
- frame_ack while frame_valid=0: ignored.
- clear (priority over all except n_rst): sample_count<=0, state<=COLLECT, frame_valid<=0, overflow<=0. par_out and buffer contents are not changed. A strobe in the same cycle is discarded.
- in_strobe and frame_ack in the same COLLECT cycle: both take effect independently per the rules above.
- Reset mid-frame: the partial frame is lost and the next strobe goes to slot 0.
- par_out changes only on frame transfer. It is stable throughout frame_valid=1 until the ack edge.

Test Plan:
- Reset then 32 strobes with serial_in=0x0000..0x001F, no ack -> frame_valid=1 one cycle after 32nd strobe; par_out word k = k; sample_count=0; overflow=0.
- Continue with 32 strobes 0x0100..0x011F while frame_valid held (no ack) -> PENDING after 32nd, par_out still 0x0000..; then ack -> next cycle par_out word k = 0x0100+k, frame_valid=1, sample_count=0.
- In PENDING, pulse in_strobe with 0xDEAD -> overflow=1 sticky; after ack the frame contains no 0xDEAD; clear -> overflow=0.
- Back-to-back streaming: strobe every cycle for 96 samples, ack in the same cycle as each 32nd strobe -> three frames delivered, frame_valid never drops, overflow=0.
- Assert n_rst after 10 samples, release, then send 32 samples 0xA000+k -> par_out word k = 0xA000+k (slot 0 = first sample after reset).
- Pulse clear at sample_count=17 together with in_strobe -> sample_count=0, frame_valid=0; the following 32 samples form a clean frame.

Source files
------------

// File: rtl/stp_buffer.sv
// rtl/stp_buffer.sv - serial-to-parallel frame collector with one-frame collect buffer
// Gathers NUM_SAMPLES serial samples and hands them to the consumer as one flat word with valid/ack.
module stp_buffer #(
  parameter int DATA_W      = 16,
  parameter int NUM_SAMPLES = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          clear,
  input  logic                          in_strobe,
  input  logic [DATA_W-1:0]             serial_in,
  output logic [NUM_SAMPLES*DATA_W-1:0] par_out,
  output logic                          frame_valid,
  input  logic                          frame_ack,
  output logic [$clog2(NUM_SAMPLES)-1:0] sample_count,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_SAMPLES - 1);

  typedef enum logic {COLLECT, PENDING} state_t;

  state_t state, next_state;

  logic [NUM_SAMPLES-1:0][DATA_W-1:0] coll_buf;
  logic [NUM_SAMPLES-1:0][DATA_W-1:0] done_frame;
  logic hold_free, at_last, take, frame_done, park, pend_xfer;

  always_comb begin
    hold_free  = !frame_valid || frame_ack;
    at_last    = (sample_count == LAST_SLOT);
    take       = in_strobe && (state == COLLECT);
    frame_done = take && at_last && hold_free;
    park       = take && at_last && !hold_free;
    pend_xfer  = (state == PENDING) && frame_ack;
    // The completing sample bypasses the buffer straight into the output word.
    done_frame = coll_buf;
    done_frame[NUM_SAMPLES-1] = serial_in;
    next_state = state;
    case (state)
      COLLECT: if (park) next_state = PENDING;
      PENDING: if (frame_ack) next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
    if (clear) next_state = COLLECT;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= COLLECT;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coll_buf     <= '0;
      par_out      <= '0;
      frame_valid  <= 1'b0;
      sample_count <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      frame_valid  <= 1'b0;
      sample_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (take && !at_last) begin
        coll_buf[sample_count] <= serial_in;
        sample_count           <= sample_count + CNT_W'(1);
      end
      if (park) coll_buf[NUM_SAMPLES-1] <= serial_in;
      // A transfer keeps frame_valid high; a bare ack retires the held frame.
      if (frame_done) begin
        par_out      <= done_frame;
        frame_valid  <= 1'b1;
        sample_count <= '0;
      end else if (pend_xfer) begin
        par_out      <= coll_buf;
        sample_count <= '0;
      end else if (frame_ack) begin
        frame_valid  <= 1'b0;
      end
      if ((state == PENDING) && in_strobe) overflow <= 1'b1;
    end
  end

endmodule
